inst_stream_fetch: RTL and testbench
====================================

# inst_stream_fetch

Command-stream fetcher for the graphics pipeline: reads command words out of the asynchronous-read instruction memory through its header port (`addr1`/`read0`) and four-word argument port (`addr2`/`read1..read4`). Decodes each header, presents it downstream with a valid/ready handshake, then streams the argument words in beats of up to four. It sits between the instruction memory and the transform/raster command consumer, and runs from `start` until it reaches an end-of-stream header.

## Interface
- `MEM_DEPTH`, 51: number of valid memory words; word addresses `0..MEM_DEPTH-1`.
- `clk` input 1: core clock; also clocks the instruction memory's write port.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins fetching at `base_addr`. Ignored unless the block is idle.
- `base_addr` input 32: word address of the first header.
- `addr1` output 32: header word address (program counter).
- `read0` input 32: `mem[addr1]`, combinational.
- `addr2` output 32: first argument word address of the current beat.
- `read1`..`read4` input 32 each: `mem[addr2]`..`mem[addr2+3]`, combinational.
- `cmd_valid` output 1: decoded header is available.
- `cmd_ready` input 1: consumer accepts the header.
- `cmd_op` output 8: opcode, `header[7:0]`.
- `cmd_field` output 8: `header[15:8]`.
- `cmd_has_args` output 1: `header[31]`.
- `arg_valid` output 1: argument beat is available.
- `arg_ready` input 1: consumer accepts the beat.
- `arg_data` output 128: `{read1,read2,read3,read4}`, with `read1` in bits [127:96].
- `arg_cnt` output 3: number of valid words in the beat (1–4), taken from the MSB side.
- `arg_last` output 1: final beat of the current command.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when an end-of-stream header is reached.
- `error` output 1: sticky address-overflow flag; cleared by `start` or `rst`.

## Operation
- Header format:
  - bit31 = 1: the command has an argument payload, and `header[15:8]` is the argument count N (0–255).
  - bit31 = 0: `header[15:8]` is an immediate and N = 0.
  - `header[7:0]` is the opcode.
  - Header `32'h00000000` means end of stream.
  - Example encodings: `80000304` is color with 3 args; `80001011` is rotate with 16 args; `00000110` is matrix mode with immediate 1; `00000005` is flush.
- States: IDLE, HDR, CMD, ARGS, DONE.
  - **IDLE:** on `start`, load `addr1 <= base_addr`, clear `error`, go to HDR.
  - **HDR:**
    - If `addr1 >= MEM_DEPTH`: set `error`, go to IDLE.
    - Else, if `read0 == 0`: go to DONE.
    - Else, if bit31 = 1 and `addr1 + N >= MEM_DEPTH`: set `error`, go to IDLE without issuing the command.
    - Otherwise: latch the header fields and the remaining count `rem <= N`, go to CMD.
  - **CMD:**
    - `cmd_valid` = 1. Outputs hold until `cmd_ready`.
    - On the handshake, if `rem > 0`: set `addr2 <= addr1 + 1` and go to ARGS.
    - On the handshake, if `rem == 0`: set `addr1 <= addr1 + 1` and go to HDR.
  - **ARGS:**
    - `arg_valid` = 1, `arg_cnt = min(rem, 4)`, `arg_last = (rem <= 4)`.
    - On `arg_ready`: `addr2 += arg_cnt`, `rem -= arg_cnt`.
    - If that was the last beat: set `addr1 <= addr2 + arg_cnt` and go to HDR.
  - **DONE:** `done` = 1 for one cycle, then go to IDLE.
- Address arithmetic is 32-bit unsigned; the bounds checks guarantee no wrap.
- Words past `arg_cnt` in `arg_data` are don't-care.
- The block never writes memory.
- Writes to memory during a run are not protected; software must not write while `busy`.

## Timing
- Reset values: `addr1 = 0`, `addr2 = 0`, state IDLE. `cmd_valid`, `arg_valid`, `arg_last`, `busy`, `done` and `error` are all 0. `cmd_*` and `arg_cnt` are 0.
- `start` sampled at cycle t → HDR at t+1 → `cmd_valid` high at t+2.
- Command with no args and `cmd_ready` held high: 2 cycles per command (HDR, CMD).
- Command with N args and both readies held high: 2 + ceil(N/4) cycles.
- `cmd_valid` and `arg_valid` are never high in the same cycle.
- Once asserted, valid stays high and its payload stays stable until accepted.
- `arg_data` is combinational from the memory, and stays stable because `addr2` is registered and changes only on a handshake.
- A `start` pulse while `busy` is ignored and does not affect `error`.
- `rst` in any state returns to the reset values on the next edge; any partially streamed command is abandoned.
- `done` and `error` are mutually exclusive for a given run.

## Test plan
- **Color command:** memory preloaded with `80000304, 3F800000, 0, 0`, then `0` at word 4; `base_addr = 0`; readies held high.
  - Cycle t+2: `cmd_op = 04`, `cmd_field = 03`.
  - Next cycle: one beat with `arg_cnt = 3`, `arg_last = 1`, `arg_data[127:96] = 3F800000`.
  - `done` pulses after the word-4 header.
- **Rotate command:** header `80001011` followed by 16 args.
  - Four beats with `arg_cnt = 4`; `arg_last` only on the fourth.
  - `addr2` advances 1, 5, 9, 13; the next header is read at address 17.
- **Immediate command:** header `00000110` → `cmd_op = 10`, `cmd_field = 01`, `cmd_has_args = 0`, no arg beat, `addr1` advances by 1.
- **Backpressure:** hold `cmd_ready` low for 5 cycles, then toggle `arg_ready` randomly.
  - Valid and payload stay stable while unaccepted; no word is skipped or duplicated.
- **Overflow:** `base_addr = 49`, header `80000304` at 49.
  - No `cmd_valid`; `error = 1`, `busy = 0`.
  - The next `start` clears `error`.
- **Reset and start mid-run:** assert `rst` for one cycle mid-ARGS → all outputs return to reset values next cycle. A `start` pulse while `busy` is ignored and `addr1` is unchanged.

Source files
------------

// File: rtl/inst_stream_fetch.sv
// ---------------------------------------------------------------------------
// inst_stream_fetch
//
// Command-stream fetcher. It walks a command stream held in an asynchronous-
// read instruction memory. Each header word is decoded and offered downstream
// on a valid/ready handshake. Its argument words are then streamed in beats of
// up to four words. A run starts on `start` and ends at an all-zero header
// (done) or on an address overflow (error).
//
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   start, base_addr    begin a run at word address base_addr (idle only)
//   addr1 / read0       header address and the memory word at that address
//   addr2 / read1..4    argument beat address and mem[addr2..addr2+3]
//   cmd_*               decoded header with valid/ready handshake
//   arg_*               argument beat (MSB-aligned words) with valid/ready
//   busy                high in every state except idle
//   done                one-cycle pulse on reaching end of stream
//   error               sticky overflow flag, cleared by start or rst
// ---------------------------------------------------------------------------
module inst_stream_fetch #(
    parameter int unsigned MEM_DEPTH = 51
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  base_addr,
    output logic [31:0]  addr1,
    input  logic [31:0]  read0,
    output logic [31:0]  addr2,
    input  logic [31:0]  read1,
    input  logic [31:0]  read2,
    input  logic [31:0]  read3,
    input  logic [31:0]  read4,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic [7:0]   cmd_op,
    output logic [7:0]   cmd_field,
    output logic         cmd_has_args,
    output logic         arg_valid,
    input  logic         arg_ready,
    output logic [127:0] arg_data,
    output logic [2:0]   arg_cnt,
    output logic         arg_last,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CMD,
        S_ARGS,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr1_q, addr1_d;
    logic [31:0] addr2_q, addr2_d;
    logic [7:0]  rem_q, rem_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  field_q, field_d;
    logic        has_args_q, has_args_d;
    logic        error_q, error_d;

    logic [7:0]  hdr_n;
    logic [2:0]  beat_cnt;
    logic        beat_last;
    logic [31:0] read_words [4];

    // Argument count carried by the header; immediates carry no payload.
    assign hdr_n     = read0[31] ? read0[15:8] : 8'd0;
    assign beat_cnt  = (rem_q >= 8'd4) ? 3'd4 : rem_q[2:0];
    assign beat_last = (rem_q <= 8'd4);

    // Argument words are packed MSB-first: read1 lands in bits [127:96].
    assign read_words[0] = read1;
    assign read_words[1] = read2;
    assign read_words[2] = read3;
    assign read_words[3] = read4;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pack
            assign arg_data[127-32*gi -: 32] = read_words[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr1_q    <= '0;
            addr2_q    <= '0;
            rem_q      <= '0;
            op_q       <= '0;
            field_q    <= '0;
            has_args_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr1_q    <= addr1_d;
            addr2_q    <= addr2_d;
            rem_q      <= rem_d;
            op_q       <= op_d;
            field_q    <= field_d;
            has_args_q <= has_args_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr1_d    = addr1_q;
        addr2_d    = addr2_q;
        rem_d      = rem_q;
        op_d       = op_q;
        field_d    = field_q;
        has_args_d = has_args_q;
        error_d    = error_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr1_d = base_addr;
                    error_d = 1'b0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (addr1_q >= DEPTH) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (read0 == 32'd0) begin
                    state_d = S_DONE;
                end else if (read0[31] && ((addr1_q + {24'd0, hdr_n}) >= DEPTH)) begin
                    // The payload would run past the end of memory; drop the
                    // command entirely rather than issue a truncated one.
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    op_d       = read0[7:0];
                    field_d    = read0[15:8];
                    has_args_d = read0[31];
                    rem_d      = hdr_n;
                    state_d    = S_CMD;
                end
            end
            S_CMD: begin
                if (cmd_ready) begin
                    if (rem_q != 8'd0) begin
                        addr2_d = addr1_q + 32'd1;
                        state_d = S_ARGS;
                    end else begin
                        addr1_d = addr1_q + 32'd1;
                        state_d = S_HDR;
                    end
                end
            end
            S_ARGS: begin
                if (arg_ready) begin
                    addr2_d = addr2_q + {29'd0, beat_cnt};
                    rem_d   = rem_q - {5'd0, beat_cnt};
                    if (beat_last) begin
                        // The next header follows the final argument word.
                        addr1_d = addr2_q + {29'd0, beat_cnt};
                        state_d = S_HDR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign addr1        = addr1_q;
    assign addr2        = addr2_q;
    assign cmd_valid    = (state_q == S_CMD);
    assign cmd_op       = op_q;
    assign cmd_field    = field_q;
    assign cmd_has_args = has_args_q;
    assign arg_valid    = (state_q == S_ARGS);
    assign arg_cnt      = arg_valid ? beat_cnt : 3'd0;
    assign arg_last     = arg_valid && beat_last;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign error        = error_q;

endmodule

// File: tb/tb_inst_stream_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_stream_fetch
//
// Scoreboard bench. A reference walk of the memory image predicts the command
// headers, the argument beats and the run outcome (done or error). A separate
// monitor pops and compares these whenever the fetcher completes a handshake
// or ends a run. The monitor also checks that payloads stay stable under
// backpressure.
// ---------------------------------------------------------------------------
module tb_inst_stream_fetch;

    localparam int DEPTH = 51;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  base_addr;
    logic [31:0]  addr1, addr2;
    logic [31:0]  read0, read1, read2, read3, read4;
    logic         cmd_valid, cmd_ready;
    logic [7:0]   cmd_op, cmd_field;
    logic         cmd_has_args;
    logic         arg_valid, arg_ready;
    logic [127:0] arg_data;
    logic [2:0]   arg_cnt;
    logic         arg_last, busy, done, error;

    always #5 clk = ~clk;

    inst_stream_fetch #(.MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .addr1(addr1), .read0(read0), .addr2(addr2),
        .read1(read1), .read2(read2), .read3(read3), .read4(read4),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_field(cmd_field), .cmd_has_args(cmd_has_args),
        .arg_valid(arg_valid), .arg_ready(arg_ready), .arg_data(arg_data),
        .arg_cnt(arg_cnt), .arg_last(arg_last),
        .busy(busy), .done(done), .error(error)
    );

    // Asynchronous-read instruction memory; out-of-range reads return 0.
    logic [31:0] mem [0:DEPTH-1];

    always_comb begin
        read0 = (addr1 < 32'(DEPTH)) ? mem[addr1] : 32'd0;
        read1 = (addr2 < 32'(DEPTH)) ? mem[addr2] : 32'd0;
        read2 = (addr2 + 32'd1 < 32'(DEPTH)) ? mem[addr2 + 32'd1] : 32'd0;
        read3 = (addr2 + 32'd2 < 32'(DEPTH)) ? mem[addr2 + 32'd2] : 32'd0;
        read4 = (addr2 + 32'd3 < 32'(DEPTH)) ? mem[addr2 + 32'd3] : 32'd0;
    end

    typedef struct {
        logic [7:0] op;
        logic [7:0] field;
        logic       has;
    } cmd_t;

    typedef struct {
        logic [31:0]  a2;
        logic [2:0]   cnt;
        logic         last;
        logic [127:0] data;
    } beat_t;

    cmd_t  cmd_q[$];
    beat_t beat_q[$];
    int    out_q[$];   // 0 = done, 1 = error

    int total = 0;
    int bad   = 0;

    int cmd_mode = 1;  // 0 low, 1 high, 2 random
    int arg_mode = 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mask_words(input logic [127:0] d, input logic [2:0] c);
        logic [127:0] r;
        r = d;
        for (int i = 0; i < 4; i++)
            if (i >= int'(c)) r[127-32*i -: 32] = 32'd0;
        return r;
    endfunction

    // Reference walk of the command stream starting at base.
    task automatic build_expect(input logic [31:0] base);
        logic [31:0]  pc, h, a;
        int           n, rem, c;
        logic [127:0] data;
        pc = base;
        for (int guard = 0; guard < 200; guard++) begin
            if (pc >= 32'(DEPTH)) begin
                out_q.push_back(1);
                return;
            end
            h = mem[pc];
            if (h == 32'd0) begin
                out_q.push_back(0);
                return;
            end
            n = h[31] ? int'(h[15:8]) : 0;
            if (h[31] && (int'(pc) + n >= DEPTH)) begin
                out_q.push_back(1);
                return;
            end
            cmd_q.push_back('{op: h[7:0], field: h[15:8], has: h[31]});
            if (n > 0) begin
                a   = pc + 32'd1;
                rem = n;
                while (rem > 0) begin
                    c    = (rem > 4) ? 4 : rem;
                    data = '0;
                    for (int i = 0; i < c; i++)
                        data[127-32*i -: 32] = mem[a + 32'(i)];
                    beat_q.push_back('{a2: a, cnt: 3'(c), last: (rem <= 4), data: data});
                    a   = a + 32'(c);
                    rem = rem - c;
                end
                pc = a;
            end else begin
                pc = pc + 32'd1;
            end
        end
    endtask

    // Ready driver.
    initial begin
        cmd_ready = 1'b1;
        arg_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cmd_ready = (cmd_mode == 2) ? 1'($urandom_range(0, 1)) : (cmd_mode == 1);
            arg_ready = (arg_mode == 2) ? 1'($urandom_range(0, 1)) : (arg_mode == 1);
        end
    end

    // Monitor / scoreboard.
    logic         busy_prev = 1'b0, done_prev = 1'b0;
    logic         cmd_hold = 1'b0, arg_hold = 1'b0;
    logic [16:0]  cmd_snap;
    logic [163:0] arg_snap;

    initial begin
        cmd_t  ec;
        beat_t eb;
        int    eo;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 1'b0;
                done_prev = 1'b0;
                cmd_hold  = 1'b0;
                arg_hold  = 1'b0;
            end else begin
                if (cmd_hold)
                    check("cmd_stable", {cmd_valid, cmd_op, cmd_field, cmd_has_args}, {1'b1, cmd_snap});
                if (arg_hold)
                    check("arg_stable", {arg_valid, arg_cnt, arg_last, addr2, arg_data}, {1'b1, arg_snap});
                cmd_hold = 1'b0;
                arg_hold = 1'b0;
                if (cmd_valid || arg_valid)
                    check("valid_exclusive", {cmd_valid, arg_valid} == 2'b11, 0);
                if (cmd_valid) begin
                    if (cmd_ready) begin
                        total++;
                        if (cmd_q.size() == 0) begin
                            bad++;
                            $display("FAIL cmd_unexpected: got op=%0h want none", cmd_op);
                        end else begin
                            ec = cmd_q.pop_front();
                            check("cmd", {cmd_op, cmd_field, cmd_has_args}, {ec.op, ec.field, ec.has});
                        end
                    end else begin
                        cmd_hold = 1'b1;
                        cmd_snap = {cmd_op, cmd_field, cmd_has_args};
                    end
                end
                if (arg_valid) begin
                    if (arg_ready) begin
                        total++;
                        if (beat_q.size() == 0) begin
                            bad++;
                            $display("FAIL beat_unexpected: got addr2=%0d want none", addr2);
                        end else begin
                            eb = beat_q.pop_front();
                            check("beat_ctl", {addr2, arg_cnt, arg_last}, {eb.a2, eb.cnt, eb.last});
                            check("beat_data", mask_words(arg_data, arg_cnt), eb.data);
                        end
                    end else begin
                        arg_hold = 1'b1;
                        arg_snap = {arg_cnt, arg_last, addr2, arg_data};
                    end
                end
                if (done || (busy_prev && !busy && !done_prev)) begin
                    total++;
                    if (out_q.size() == 0) begin
                        bad++;
                        $display("FAIL outcome_unexpected: got done=%0b err=%0b want none", done, error);
                    end else begin
                        eo = out_q.pop_front();
                        check("outcome", {done, error}, (eo == 0) ? 2'b10 : 2'b01);
                    end
                end
                busy_prev = busy;
                done_prev = done;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    endtask

    task automatic start_run(input logic [31:0] b);
        build_expect(b);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 3000);
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL %s_timeout: got busy=1 want busy=0 within 3000 cycles", name);
        end
        @(negedge clk);
        #1;
        check({name, "_cmdq_left"},  cmd_q.size(),  0);
        check({name, "_beatq_left"}, beat_q.size(), 0);
        check({name, "_outq_left"},  out_q.size(),  0);
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {addr1, addr2, cmd_valid, arg_valid, arg_last, busy, done, error,
                     cmd_op, cmd_field, cmd_has_args, arg_cnt}, 0);
    endtask

    task automatic load_rotate();
        clear_mem();
        mem[0] = 32'h80001011;
        for (int i = 1; i <= 16; i++) mem[i] = $urandom;
        mem[17] = 32'h00000110;
        mem[18] = 32'h00000005;
        mem[19] = 32'h00000000;
    endtask

    initial begin
        int n;
        int pc;
        int r;
        start     = 1'b0;
        base_addr = 32'd0;
        rst       = 1'b1;
        clear_mem();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_values");

        // Color command with header-latency checks.
        clear_mem();
        mem[0] = 32'h80000304;
        mem[1] = 32'h3F800000;
        start_run(32'd0);
        @(negedge clk);
        check("hdr_cycle", {busy, cmd_valid}, 2'b10);
        @(negedge clk);
        check("cmd_at_t2", {cmd_valid, cmd_op, cmd_field}, {1'b1, 8'h04, 8'h03});
        wait_idle("color");

        // Rotate: four full beats, then an immediate and a flush.
        load_rotate();
        start_run(32'd0);
        wait_idle("rotate");

        // Backpressure with an ignored start while the header is held.
        load_rotate();
        cmd_mode = 0;
        start_run(32'd0);
        n = 0;
        while (!cmd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_cmd_reached", cmd_valid, 1'b1);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("ignored_start", {addr1, cmd_valid, error}, {32'd0, 1'b1, 1'b0});
        repeat (3) @(negedge clk);
        cmd_mode = 1;
        arg_mode = 2;
        wait_idle("backpressure");
        arg_mode = 1;

        // Overflow: payload runs past memory end.
        clear_mem();
        mem[49] = 32'h80000304;
        start_run(32'd49);
        wait_idle("overflow");
        check("overflow_flags", {error, busy}, 2'b10);
        start_run(32'd0);
        @(negedge clk);
        check("error_cleared", error, 1'b0);
        wait_idle("after_overflow");

        // Boundaries: payload ending on the last word, and one word past it.
        clear_mem();
        mem[46] = 32'h80000407;
        for (int i = 47; i < DEPTH; i++) mem[i] = $urandom;
        start_run(32'd46);
        wait_idle("edge_fit");
        check("edge_fit_err", error, 1'b1);
        mem[47] = 32'h80000408;
        start_run(32'd47);
        wait_idle("edge_over");
        start_run(32'd60);
        wait_idle("base_out_of_range");

        // Reset in the middle of an argument stream.
        load_rotate();
        arg_mode = 2;
        start_run(32'd0);
        n = 0;
        while (!arg_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_args_reached", arg_valid, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cmd_q.delete();
        beat_q.delete();
        out_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_mid_args");
        start_run(32'd0);
        wait_idle("after_reset");

        // Randomized programs with random backpressure.
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
            pc = $urandom_range(0, 5);
            while (pc < DEPTH) begin
                r = $urandom_range(0, 11);
                if (r == 0) begin
                    mem[pc] = 32'd0;
                    break;
                end else if (r <= 7) begin
                    n = $urandom_range(0, 12);
                    mem[pc] = {1'b1, 15'($urandom), 8'(n), 8'($urandom)};
                    pc = pc + 1 + n;
                end else begin
                    mem[pc] = {1'b0, 15'($urandom), 8'($urandom), 8'($urandom_range(1, 255))};
                    pc = pc + 1;
                end
            end
            cmd_mode = $urandom_range(1, 2);
            arg_mode = $urandom_range(1, 2);
            start_run(32'($urandom_range(0, 5)));
            wait_idle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule
